// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared count width, timing tuple, standard presets and region-boundary helper
package video_timing_pkg;

    localparam int COUNT_W = 12;

    typedef struct packed {
        logic [COUNT_W:0] active;
        logic [COUNT_W:0] fp;
        logic [COUNT_W:0] sync;
        logic [COUNT_W:0] bp;
    } timing_t;

    typedef struct packed {
        logic [COUNT_W:0] total;
        logic [COUNT_W:0] sync_start;
        logic [COUNT_W:0] sync_end;
    } bounds_t;

    localparam timing_t TIMING_1080P60_H = '{13'd1920, 13'd88, 13'd44, 13'd148};
    localparam timing_t TIMING_1080P60_V = '{13'd1080, 13'd4, 13'd5, 13'd36};
    localparam timing_t TIMING_720P60_H  = '{13'd1280, 13'd110, 13'd40, 13'd220};
    localparam timing_t TIMING_720P60_V  = '{13'd720, 13'd5, 13'd5, 13'd20};

    function automatic bounds_t axis_bounds(input timing_t t);
        bounds_t b;
        b.total      = t.active + t.fp + t.sync + t.bp;
        b.sync_start = t.active + t.fp;
        b.sync_end   = t.active + t.fp + t.sync;
        return b;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter: one wrapping raster axis counter with carry-out and sync/active comparators
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL      = 16,
    parameter int SYNC_START = 10,
    parameter int SYNC_END   = 13,
    parameter int ACTIVE     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               sync,
    output logic               active
);

    localparam logic [COUNT_W:0] LAST = (COUNT_W+1)'(TOTAL - 1);
    localparam logic [COUNT_W:0] SS   = (COUNT_W+1)'(SYNC_START);
    localparam logic [COUNT_W:0] SE   = (COUNT_W+1)'(SYNC_END);
    localparam logic [COUNT_W:0] ACT  = (COUNT_W+1)'(ACTIVE);

    logic [COUNT_W:0] cx;
    logic             last;

    assign cx     = {1'b0, count};
    assign last   = cx == LAST;
    assign wrap   = step && last;
    assign sync   = cx >= SS && cx < SE;
    assign active = cx < ACT;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (step)
            count <= last ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster h/v counters with hsync/vsync/de/frame_start delayed to match downstream RGB registers
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int PIPE_DLY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [COUNT_W-1:0] h_count,
    output logic [COUNT_W-1:0] v_count,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start
);

    if (H_ACTIVE + H_FP + H_SYNC + H_BP > 4096 || V_ACTIVE + V_FP + V_SYNC + V_BP > 4096) begin : g_bad_total
        $error("video_timing_gen: H or V total exceeds 4096");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("video_timing_gen: PIPE_DLY must be 0..7");
    end

    localparam timing_t HT = '{13'(H_ACTIVE), 13'(H_FP), 13'(H_SYNC), 13'(H_BP)};
    localparam timing_t VT = '{13'(V_ACTIVE), 13'(V_FP), 13'(V_SYNC), 13'(V_BP)};
    localparam bounds_t HB = axis_bounds(HT);
    localparam bounds_t VB = axis_bounds(VT);

    logic       h_wrap, hs_i, vs_i, h_act, v_act, frame_end_unused;
    logic [3:0] flags, dly;

    video_axis_counter #(
        .TOTAL(int'(HB.total)), .SYNC_START(int'(HB.sync_start)),
        .SYNC_END(int'(HB.sync_end)), .ACTIVE(H_ACTIVE)
    ) u_h (
        .clk(clk), .reset(reset), .step(en),
        .count(h_count), .wrap(h_wrap), .sync(hs_i), .active(h_act)
    );

    // Vertical axis advances only on the horizontal wrap, so both wrap on one edge
    video_axis_counter #(
        .TOTAL(int'(VB.total)), .SYNC_START(int'(VB.sync_start)),
        .SYNC_END(int'(VB.sync_end)), .ACTIVE(V_ACTIVE)
    ) u_v (
        .clk(clk), .reset(reset), .step(h_wrap),
        .count(v_count), .wrap(frame_end_unused), .sync(vs_i), .active(v_act)
    );

    assign flags = {hs_i, vs_i, h_act && v_act, h_count == '0 && v_count == '0};

    if (PIPE_DLY == 0) begin : g_nodly
        // Counts sit at 0,0 during reset; mask so reset still shows inactive flags
        assign dly = reset ? 4'b0 : flags;
    end else begin : g_dly
        logic [3:0] sr [PIPE_DLY];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DLY; i++) sr[i] <= '0;
            end else if (en) begin
                sr[0] <= flags;
                for (int i = 1; i < PIPE_DLY; i++) sr[i] <= sr[i-1];
            end
        end
        assign dly = sr[PIPE_DLY-1];
    end

    assign hsync       = HS_POL != 0 ? dly[3] : ~dly[3];
    assign vsync       = VS_POL != 0 ? dly[2] : ~dly[2];
    assign de          = dly[1];
    assign frame_start = dly[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of three timing_gen instances (delay 1, delay 0 inverted polarity, delay 3)
module tb_video_timing_gen;

    logic        clk = 1'b0, reset = 1'b1, en = 1'b0;
    logic [11:0] h1, v1, h0, v0, h3, v3;
    logic        hs1, vs1, de1, fs1, hs0, vs0, de0, fs0, hs3, vs3, de3, fs3;

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIPE_DLY(1)) u_d1 (.clk(clk), .reset(reset), .en(en), .h_count(h1), .v_count(v1),
        .hsync(hs1), .vsync(vs1), .de(de1), .frame_start(fs1));
    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .PIPE_DLY(0)) u_d0 (.clk(clk), .reset(reset), .en(en), .h_count(h0), .v_count(v0),
        .hsync(hs0), .vsync(vs0), .de(de0), .frame_start(fs0));
    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIPE_DLY(3)) u_d3 (.clk(clk), .reset(reset), .en(en), .h_count(h3), .v_count(v3),
        .hsync(hs3), .vsync(vs3), .de(de3), .frame_start(fs3));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int mh = 0, mv = 0;
    int hh[3], hv[3];
    bit hval[3];
    int de_n, hs_n, vs_n, fs_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (model h=%0d v=%0d)", tag, got, exp, mh, mv);
        end
    endtask

    // {hs, vs, de, fs} expected for a presented count; invalid slots are the reset-flushed state
    function automatic logic [3:0] fl(input bit ok, input int h, input int v);
        if (!ok) return 4'b0;
        return {h >= 10 && h < 13, v >= 5 && v < 7, h < 8 && v < 4, h == 0 && v == 0};
    endfunction

    task automatic step(input bit r, input bit e);
        logic [3:0] f1, f0, f3;
        reset = r;
        en    = e;
        @(posedge clk);
        if (r) begin
            mh = 0;
            mv = 0;
            for (int i = 0; i < 3; i++) hval[i] = 0;
        end else if (e) begin
            for (int i = 2; i > 0; i--) begin
                hh[i] = hh[i-1]; hv[i] = hv[i-1]; hval[i] = hval[i-1];
            end
            hh[0] = mh; hv[0] = mv; hval[0] = 1;
            if (mh == 15) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        @(negedge clk);
        f1 = fl(hval[0], hh[0], hv[0]);
        f3 = fl(hval[2], hh[2], hv[2]);
        f0 = fl(!r, mh, mv);
        check("h_d1", h1, mh);  check("v_d1", v1, mv);
        check("h_d0", h0, mh);  check("v_d0", v0, mv);
        check("h_d3", h3, mh);  check("v_d3", v3, mv);
        check("hs_d1", hs1, f1[3]); check("vs_d1", vs1, f1[2]); check("de_d1", de1, f1[1]); check("fs_d1", fs1, f1[0]);
        check("hs_d0", hs0, !f0[3]); check("vs_d0", vs0, !f0[2]); check("de_d0", de0, f0[1]); check("fs_d0", fs0, f0[0]);
        check("hs_d3", hs3, f3[3]); check("vs_d3", vs3, f3[2]); check("de_d3", de3, f3[1]); check("fs_d3", fs3, f3[0]);
        de_n += int'(de1); hs_n += int'(hs1); vs_n += int'(vs1); fs_n += int'(fs1);
    endtask

    task automatic seek(input int h, input int v);
        for (int i = 0; i < 300 && !(mh == h && mv == v); i++) step(0, 1);
        check("seek", mh == h && mv == v, 1);
    endtask

    initial begin
        step(1, 1);
        step(1, 1);
        check("rst_hs_d1", hs1, 0);
        check("rst_de_d1", de1, 0);
        check("rst_hs_d0", hs0, 1);
        check("rst_vs_d0", vs0, 1);
        check("rst_fs_d0", fs0, 0);

        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
        step(0, 1);
        check("rel_h", h1, 1);
        check("rel_fs", fs1, 1);
        check("rel_de_d3", de3, 0);
        step(0, 1);
        check("rel_fs_once", fs1, 0);
        step(0, 1);
        check("d3_de_rise", de3, 1);
        check("d3_fs", fs3, 1);
        for (int i = 0; i < 125; i++) step(0, 1);
        check("frame_de", de_n, 32);
        check("frame_hs", hs_n, 24);
        check("frame_vs", vs_n, 32);
        check("frame_fs", fs_n, 1);

        seek(6, 2);
        repeat (5) step(0, 0);
        check("hold_h", h1, 6);
        check("hold_v", v1, 2);
        step(0, 1);
        check("resume_h", h1, 7);
        check("resume_v", v1, 2);

        seek(13, 7);
        step(1, 1);
        check("mid_rst_h", h1, 0);
        check("mid_rst_v", v1, 0);
        check("mid_rst_fs", fs1, 0);
        check("mid_rst_vs", vs1, 0);
        step(0, 1);
        check("restart_fs", fs1, 1);
        for (int i = 0; i < 140; i++) step(0, 1);

        seek(15, 7);
        step(1, 1);
        check("wrap_rst_h", h1, 0);
        check("wrap_rst_v", v1, 0);
        for (int i = 0; i < 20; i++) step(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
